// File: rtl/golomb_exp_codeword_gen.sv
// -----------------------------------------------------------------------------
// golomb_exp_codeword_gen
//
// ProRes hybrid VLC codeword generator for the slice entropy path. Each input
// beat carries one coefficient magnitude plus its codebook parameters. It is
// encoded with Rice below the switch point and exp-Golomb at or above it. An
// AC sign bit can optionally be appended. The result is a right-aligned
// codeword plus its length, which goes to the bitstream packer.
//
// Ports
//   clk, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_start/in_end     slice framing, carried alongside the beat
//   in_val              unsigned magnitude to encode
//   in_rice_k           Rice order
//   in_exp_k            exp-Golomb order
//   in_switch_bits      last Rice quotient (switch point)
//   in_sign_en/in_sign  append sign bit (1 = negative)
//   out_valid/out_ready output handshake
//   out_start/out_end   framing aligned with the output beat
//   out_codeword        LSB-aligned codeword, zero when the beat overflows
//   out_len             true codeword length in bits
//   out_overflow        length of this beat exceeds CW_W
//   err_sticky          latched overflow indication
//   err_clear           synchronous clear of err_sticky (a new overflow wins)
//
// Handshake: a beat transfers on any edge where valid & ready are both high.
// A producer holds its valid and payload until that happens. Each of the
// three stages loads when it is empty, or when its current content moves on
// in the same cycle. Ready therefore ripples combinationally back from
// out_ready. While out_valid is high and out_ready is low, every out_* is held.
// -----------------------------------------------------------------------------
module golomb_exp_codeword_gen #(
    parameter int VAL_W = 16,
    parameter int CW_W  = 32,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_start,
    input  logic             in_end,
    input  logic [VAL_W-1:0] in_val,
    input  logic [2:0]       in_rice_k,
    input  logic [2:0]       in_exp_k,
    input  logic [1:0]       in_switch_bits,
    input  logic             in_sign_en,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_start,
    output logic             out_end,
    output logic [CW_W-1:0]  out_codeword,
    output logic [LEN_W-1:0] out_len,
    output logic             out_overflow,
    output logic             err_sticky,
    input  logic             err_clear
);

    // Position of the highest set bit; zero for a zero input.
    function automatic logic [LEN_W-1:0] msb_index(input logic [VAL_W:0] v);
        msb_index = '0;
        for (int i = 0; i <= VAL_W; i++) begin
            if (v[i]) msb_index = LEN_W'(i);
        end
    endfunction

    // ---------------- stage occupancy and ready chain ----------------
    logic s1_full, s2_full, s3_full;
    logic s1_ready, s2_ready, s3_ready;

    assign s3_ready  = !s3_full || out_ready;
    assign s2_ready  = !s2_full || s3_ready;
    assign s1_ready  = !s1_full || s2_ready;
    assign in_ready  = s1_ready;
    assign out_valid = s3_full;

    logic s1_load, s2_load, s3_load;
    assign s1_load = in_valid && s1_ready;
    assign s2_load = s1_full && s2_ready;
    assign s3_load = s2_full && s3_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_full <= 1'b0;
            s2_full <= 1'b0;
            s3_full <= 1'b0;
        end else begin
            if (s1_ready) s1_full <= in_valid;
            if (s2_ready) s2_full <= s1_full;
            if (s3_ready) s3_full <= s2_full;
        end
    end

    // ---------------- S1: capture, first_exp, branch select ----------------
    logic [VAL_W:0] sw_plus_one_c;
    logic [VAL_W:0] first_exp_c;
    logic           is_exp_c;

    assign sw_plus_one_c = (VAL_W+1)'(in_switch_bits) + (VAL_W+1)'(1);
    assign first_exp_c   = sw_plus_one_c << in_rice_k;
    assign is_exp_c      = {1'b0, in_val} >= first_exp_c;

    logic [VAL_W-1:0] s1_val;
    logic [VAL_W:0]   s1_first_exp;
    logic             s1_is_exp;
    logic [2:0]       s1_rice_k, s1_exp_k;
    logic [1:0]       s1_switch;
    logic             s1_sign_en, s1_sign, s1_start, s1_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_val       <= '0;
            s1_first_exp <= '0;
            s1_is_exp    <= 1'b0;
            s1_rice_k    <= '0;
            s1_exp_k     <= '0;
            s1_switch    <= '0;
            s1_sign_en   <= 1'b0;
            s1_sign      <= 1'b0;
            s1_start     <= 1'b0;
            s1_end       <= 1'b0;
        end else if (s1_load) begin
            s1_val       <= in_val;
            s1_first_exp <= first_exp_c;
            s1_is_exp    <= is_exp_c;
            s1_rice_k    <= in_rice_k;
            s1_exp_k     <= in_exp_k;
            s1_switch    <= in_switch_bits;
            s1_sign_en   <= in_sign_en;
            s1_sign      <= in_sign;
            s1_start     <= in_start;
            s1_end       <= in_end;
        end
    end

    // ---------------- S2: v', leading-one detect, Rice fields ----------------
    // v' only matters on the exp branch, where val >= first_exp, so the
    // subtraction cannot wrap there.
    logic [VAL_W:0]   vp_c;
    logic [LEN_W-1:0] e_c;
    logic [LEN_W-1:0] exp_len_c;
    logic [VAL_W-1:0] rice_q_c;
    logic [LEN_W-1:0] rice_len_c;
    logic [CW_W-1:0]  one_k_c;
    logic [CW_W-1:0]  rice_cw_c;

    assign vp_c      = {1'b0, s1_val} - s1_first_exp + ((VAL_W+1)'(1) << s1_exp_k);
    assign e_c       = msb_index(vp_c);
    assign exp_len_c = (e_c - LEN_W'(s1_exp_k) + LEN_W'(s1_switch) + LEN_W'(1))
                     + (e_c + LEN_W'(1));

    // On the Rice branch the quotient is at most 3, so narrowing it is safe.
    assign rice_q_c   = s1_val >> s1_rice_k;
    assign rice_len_c = LEN_W'(rice_q_c) + LEN_W'(1) + LEN_W'(s1_rice_k);
    assign one_k_c    = CW_W'(1) << s1_rice_k;
    assign rice_cw_c  = one_k_c | (CW_W'(s1_val) & (one_k_c - CW_W'(1)));

    logic [LEN_W-1:0] s2_len;
    logic [CW_W-1:0]  s2_cw;
    logic             s2_sign_en, s2_sign, s2_start, s2_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_len     <= '0;
            s2_cw      <= '0;
            s2_sign_en <= 1'b0;
            s2_sign    <= 1'b0;
            s2_start   <= 1'b0;
            s2_end     <= 1'b0;
        end else if (s2_load) begin
            s2_len     <= s1_is_exp ? exp_len_c : rice_len_c;
            s2_cw      <= s1_is_exp ? CW_W'(vp_c) : rice_cw_c;
            s2_sign_en <= s1_sign_en;
            s2_sign    <= s1_sign;
            s2_start   <= s1_start;
            s2_end     <= s1_end;
        end
    end

    // ---------------- S3: sign, overflow, output register ----------------
    // The codeword MSB shifted out by the sign append can only be set when
    // the length already reaches CW_W, and that beat then overflows and
    // is zeroed anyway.
    logic [LEN_W-1:0] len_c;
    logic [CW_W-1:0]  cw_c;
    logic             ovf_c;

    assign len_c = s2_len + LEN_W'(s2_sign_en);
    assign cw_c  = s2_sign_en ? {s2_cw[CW_W-2:0], s2_sign} : s2_cw;
    assign ovf_c = len_c > LEN_W'(CW_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_codeword <= '0;
            out_len      <= '0;
            out_overflow <= 1'b0;
            out_start    <= 1'b0;
            out_end      <= 1'b0;
        end else if (s3_load) begin
            out_codeword <= ovf_c ? '0 : cw_c;
            out_len      <= len_c;
            out_overflow <= ovf_c;
            out_start    <= s2_start;
            out_end      <= s2_end;
        end
    end

    // A beat raises the flag once, as it enters the output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky <= 1'b0;
        end else if (s3_load && ovf_c) begin
            err_sticky <= 1'b1;
        end else if (err_clear) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_golomb_exp_codeword_gen.sv
module tb_golomb_exp_codeword_gen;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_start;
    logic        in_end;
    logic [15:0] in_val;
    logic [2:0]  in_rice_k;
    logic [2:0]  in_exp_k;
    logic [1:0]  in_switch_bits;
    logic        in_sign_en;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic        out_start;
    logic        out_end;
    logic [31:0] out_codeword;
    logic [6:0]  out_len;
    logic        out_overflow;
    logic        err_sticky;
    logic        err_clear;

    int checks;
    int failures;

    // expected output beats: {start, end, len[6:0], codeword[31:0]}
    logic [40:0] exp_q[$];

    golomb_exp_codeword_gen #(.VAL_W(16), .CW_W(32), .LEN_W(7)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_start       (in_start),
        .in_end         (in_end),
        .in_val         (in_val),
        .in_rice_k      (in_rice_k),
        .in_exp_k       (in_exp_k),
        .in_switch_bits (in_switch_bits),
        .in_sign_en     (in_sign_en),
        .in_sign        (in_sign),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_start      (out_start),
        .out_end        (out_end),
        .out_codeword   (out_codeword),
        .out_len        (out_len),
        .out_overflow   (out_overflow),
        .err_sticky     (err_sticky),
        .err_clear      (err_clear)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] v, input logic [2:0] rk, input logic [2:0] ek,
                         input logic [1:0] sw, input logic se, input logic sg,
                         input logic st, input logic en);
        in_val         = v;
        in_rice_k      = rk;
        in_exp_k       = ek;
        in_switch_bits = sw;
        in_sign_en     = se;
        in_sign        = sg;
        in_start       = st;
        in_end         = en;
        in_valid       = 1'b1;
    endtask

    // Offer one beat with out_ready high; it must appear exactly 3 clk later.
    task automatic encode_one(input string tag, input logic [15:0] v, input logic [2:0] rk,
                              input logic [2:0] ek, input logic [1:0] sw, input logic se,
                              input logic sg, input logic [31:0] exp_cw,
                              input logic [6:0] exp_len, input logic exp_ovf);
        drive(v, rk, ek, sw, se, sg, 1'b1, 1'b1);
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, "_lat2"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_cw"}, 64'(out_codeword), 64'(exp_cw));
        check({tag, "_len"}, 64'(out_len), 64'(exp_len));
        check({tag, "_ovf"}, 64'(out_overflow), 64'(exp_ovf));
        check({tag, "_frame"}, 64'({out_start, out_end}), 64'd3);
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] t5_val [5];
    logic        t5_se  [5];
    logic        t5_sg  [5];
    logic [40:0] snap;
    logic        have_snap;
    logic        acc;
    int          idx;
    int          got;

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        err_clear = 1'b0;
        drive(16'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        check("rst_out_cw", 64'(out_codeword), 64'd0);
        check("rst_err", 64'(err_sticky), 64'd0);
        reset_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_idle_valid", 64'(out_valid), 64'd0);

        // T1: Rice branch, first_exp = 12
        encode_one("t1_val5", 16'd5, 3'd2, 3'd3, 2'd2, 1'b0, 1'b0, 32'd5, 7'd4, 1'b0);
        // T2: switch boundary
        encode_one("t2_val12", 16'd12, 3'd2, 3'd3, 2'd2, 1'b0, 1'b0, 32'd8, 7'd7, 1'b0);
        encode_one("t2_val11", 16'd11, 3'd2, 3'd3, 2'd2, 1'b0, 1'b0, 32'd7, 7'd5, 1'b0);
        // T3: all orders zero
        encode_one("t3_zero", 16'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd1, 7'd1, 1'b0);
        encode_one("t3_zero_sign", 16'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 32'd3, 7'd2, 1'b0);
        // T4: widest codeword, then overflow via sign bit
        encode_one("t4_max", 16'hFFFF, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 32'h0000FFFF, 7'd32, 1'b0);
        check("t4_err_before", 64'(err_sticky), 64'd0);
        encode_one("t4_ovf", 16'hFFFF, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 32'd0, 7'd33, 1'b1);
        check("t4_err_set", 64'(err_sticky), 64'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t4_err_cleared", 64'(err_sticky), 64'd0);

        // T5: back-pressure with 5 beats, rice_k=2 switch=2 exp_k=3
        t5_val = '{16'd5, 16'd11, 16'd12, 16'd0, 16'd13};
        t5_se  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t5_sg  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_q.push_back({1'b1, 1'b0, 7'd4, 32'd5});
        exp_q.push_back({1'b0, 1'b0, 7'd5, 32'd7});
        exp_q.push_back({1'b0, 1'b0, 7'd7, 32'd8});
        exp_q.push_back({1'b0, 1'b0, 7'd4, 32'd9});
        exp_q.push_back({1'b0, 1'b1, 7'd7, 32'd9});

        out_ready = 1'b0;
        idx       = 0;
        have_snap = 1'b0;
        snap      = '0;
        for (int c = 0; c < 6; c++) begin
            drive(t5_val[idx], 3'd2, 3'd3, 2'd2, t5_se[idx], t5_sg[idx], idx == 0, idx == 4);
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (!have_snap) begin
                    snap      = {out_start, out_end, out_len, out_codeword};
                    have_snap = 1'b1;
                end else begin
                    check("t5_hold", 64'({out_start, out_end, out_len, out_codeword}), 64'(snap));
                end
            end
            tick();
            if (acc) idx++;
        end
        check("t5_accepted", 64'(idx), 64'd3);
        drive(t5_val[idx], 3'd2, 3'd3, 2'd2, t5_se[idx], t5_sg[idx], 1'b0, idx == 4);
        #1;
        check("t5_stall_ready", 64'(in_ready), 64'd0);
        check("t5_stall_valid", 64'(out_valid), 64'd1);
        check("t5_hold_last", 64'({out_start, out_end, out_len, out_codeword}), 64'(snap));

        out_ready = 1'b1;
        got       = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (idx < 5) drive(t5_val[idx], 3'd2, 3'd3, 2'd2, t5_se[idx], t5_sg[idx], idx == 0, idx == 4);
            else in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("t5_extra_beat", 64'({out_start, out_end, out_len, out_codeword}), 64'd0);
                end else begin
                    check("t5_beat", 64'({out_start, out_end, out_len, out_codeword}), 64'(exp_q.pop_front()));
                end
                got++;
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("t5_all_sent", 64'(idx), 64'd5);
        check("t5_all_out", 64'(got), 64'd5);
        #1;
        check("t5_drained", 64'(out_valid), 64'd0);

        // T6: reset with beats in flight
        drive(16'hFFFF, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(16'd5, 3'd2, 3'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(16'd11, 3'd2, 3'd3, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        check("t6_pre_ovf", 64'(out_overflow), 64'd1);
        check("t6_pre_err", 64'(err_sticky), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_fields", 64'({out_start, out_end, out_len, out_codeword}), 64'd0);
        check("t6_rst_ovf", 64'(out_overflow), 64'd0);
        check("t6_rst_err", 64'(err_sticky), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("t6_post_ready", 64'(in_ready), 64'd1);
        check("t6_post_valid", 64'(out_valid), 64'd0);
        encode_one("t6_after", 16'd5, 3'd2, 3'd3, 2'd2, 1'b0, 1'b0, 32'd5, 7'd4, 1'b0);
        tick();
        check("t6_no_stale", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
